// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder.
//   state_e     : controller states (IDLE, RUN, DONE), 2-bit encoding
//   num_chunks  : number of CHUNK-bit slices in a WIDTH-bit operand
//   idx_width   : width of the chunk index counter, never below 1 bit
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Guards against division by zero so an illegal CHUNK still elaborates
  // far enough to reach the parameter check in the top level.
  function automatic int num_chunks(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operation and result channels of the chunked sequential adder.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The sender keeps valid and its payload
// stable until that edge; ready may change freely and never depends on valid.
//   in_valid/in_ready  : operation channel, payload a, b, cin
//   out_valid/out_ready: result channel, payload sum, cout, overflow
// master = producer/consumer side, slave = the adder.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/seq_chunk_adder_ripple.sv
// chunk_ripple_adder: combinational CHUNK-bit ripple of full-adder cells.
//   a, b   : CHUNK-bit slice operands
//   cin    : carry into bit 0
//   sum    : CHUNK-bit slice result
//   cout   : carry out of bit CHUNK-1
//   c_msb  : carry into bit CHUNK-1, used for signed overflow detection
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // c[i] is the carry into bit i.
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: adds a + b + cin over WIDTH bits, CHUNK bits per clock.
// One operation in flight; result held until the consumer takes it.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : slave side of seq_chunk_adder_if (operation in, result out)
//   dbg_state : current controller state
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst,
  seq_chunk_adder_if.slave    bus,
  output state_e              dbg_state
);

  localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int IW         = idx_width(NUM_CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

  // Conditional operator keeps the modulo away from CHUNK == 0.
  localparam bit PARAM_BAD = (CHUNK < 1) ? 1'b1 :
                             ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0));

  if (PARAM_BAD) begin : g_param_err
    $error("seq_chunk_adder: WIDTH=%0d CHUNK=%0d, need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0",
           WIDTH, CHUNK);
  end

  state_e           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] sl_sum;
  logic             sl_cout;
  logic             sl_cmsb;

  // Select the operand slice addressed by idx.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry),
    .sum   (sl_sum),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high throughout IDLE outside reset.
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Only the addressed chunk of sum is written; the rest keeps its
          // old contents until its turn comes.
          for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == IW'(i)) begin
              sum_q[i*CHUNK +: CHUNK] <= sl_sum;
            end
          end
          carry <= sl_cout;
          if (idx == LAST_IDX) begin
            cout_q <= sl_cout;
            ovf_q  <= sl_cmsb ^ sl_cout;
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;
  import adder_pkg::*;

  localparam int OPS = 1000;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic sweep_go = 1'b0;
  int   sweep_done = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- main DUT: WIDTH=16, CHUNK=4 ----------------
  seq_chunk_adder_if #(.WIDTH(16)) bus ();
  state_e dbg;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) fail_now("send_in_ready");
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) fail_now("wait_result");
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int waited;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_out_valid", bus.out_valid, 1'b0);
    check("post_rst_sum", bus.sum, 16'h0000);
    check("post_rst_cout", bus.cout, 1'b0);
    check("post_rst_ovf", bus.overflow, 1'b0);
    check("post_rst_state", dbg, IDLE);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_sum", i), bus.sum, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), bus.cout, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), bus.overflow, vecs[i].ovf);
      drain();
      @(negedge clk);
      check($sformatf("vec%0d_in_ready_after_drain", i), bus.in_ready, 1'b1);
    end

    // Backpressure with an ignored in_valid pulse in the window
    send(16'h00FF, 16'h0F01, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_sum", i), bus.sum, 16'h1000);
      check($sformatf("bp%0d_out_valid", i), bus.out_valid, 1'b1);
      check($sformatf("bp%0d_in_ready", i), bus.in_ready, 1'b0);
      bus.a = 16'h1111;
      bus.b = 16'h2222;
      bus.in_valid = (i >= 3 && i <= 5);
    end
    bus.in_valid = 1'b0;
    drain();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("bp_after%0d_in_ready", i), bus.in_ready, 1'b1);
      check($sformatf("bp_after%0d_out_valid", i), bus.out_valid, 1'b0);
    end

    // Reset during the second RUN cycle
    send(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrun_after_in_ready", bus.in_ready, 1'b1);
    check("midrun_after_sum", bus.sum, 16'h0000);
    check("midrun_after_cout", bus.cout, 1'b0);
    check("midrun_after_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("midrun_no_result%0d", i), bus.out_valid, 1'b0);
    end

    // Reset while idle: in_ready must be gated by rst itself
    rst = 1'b1;
    @(negedge clk);
    check("idle_rst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_rst_after_in_ready", bus.in_ready, 1'b1);

    // Parameter sweep, random traffic
    sweep_go = 1'b1;
    waited = 0;
    while (sweep_done < 3 && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    if (sweep_done < 3) fail_now("sweep_overall");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- sweep DUTs: {8,8}, {8,1}, {32,4} ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int GW = (g == 2) ? 32 : 8;
    localparam int GC = (g == 0) ? 8 : ((g == 1) ? 1 : 4);
    localparam int GN = GW / GC;

    seq_chunk_adder_if #(.WIDTH(GW)) sbus ();
    state_e sdbg;

    seq_chunk_adder #(.WIDTH(GW), .CHUNK(GC)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (sbus),
      .dbg_state (sdbg)
    );

    int         cyc = 0;
    logic [33:0] exp_q[$];
    int         acc_q[$];
    logic       abort = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [GW-1:0] pick();
      logic [GW-1:0] v;
      case ($urandom_range(0, 4))
        0:       v = '1;
        1:       v = '0;
        2:       v = {1'b1, {(GW-1){1'b0}}};
        default: v = GW'($urandom);
      endcase
      return v;
    endfunction

    // Producer: random gaps, model a+b+cin at full precision.
    initial begin
      logic [GW-1:0] ra;
      logic [GW-1:0] rb;
      logic          rc;
      logic [GW:0]   full;
      logic          ovf;
      int            waited;
      sbus.in_valid = 1'b0;
      sbus.a = '0;
      sbus.b = '0;
      sbus.cin = 1'b0;
      wait (sweep_go);
      for (int k = 0; k < OPS && !abort; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(negedge clk);
        ra = pick();
        rb = pick();
        rc = 1'($urandom_range(0, 1));
        sbus.a = ra;
        sbus.b = rb;
        sbus.cin = rc;
        sbus.in_valid = 1'b1;
        waited = 0;
        while (!sbus.in_ready && waited < 300) begin
          @(negedge clk);
          waited++;
        end
        if (!sbus.in_ready) begin
          fail_now($sformatf("sw%0d_in_ready", g));
          abort = 1'b1;
        end else begin
          @(posedge clk);
          #1;
          full = ra + rb + rc;
          ovf  = (ra[GW-1] == rb[GW-1]) && (full[GW-1] != ra[GW-1]);
          exp_q.push_back(34'({ovf, full}));
          acc_q.push_back(cyc);
          sbus.in_valid = 1'b0;
        end
      end
    end

    // Consumer: random out_ready, check first out_valid of each result.
    initial begin
      int          done_n;
      int          idle;
      logic        seen;
      logic [33:0] e;
      int          acc;
      done_n = 0;
      idle = 0;
      seen = 1'b0;
      sbus.out_ready = 1'b0;
      wait (sweep_go);
      while (done_n < OPS && !abort) begin
        @(negedge clk);
        idle++;
        if (sbus.out_valid && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            fail_now($sformatf("sw%0d_unexpected_result", g));
          end else begin
            e   = exp_q.pop_front();
            acc = acc_q.pop_front();
            check($sformatf("sw%0d_op%0d_sum", g, done_n), sbus.sum, e[GW-1:0]);
            check($sformatf("sw%0d_op%0d_cout", g, done_n), sbus.cout, e[GW]);
            check($sformatf("sw%0d_op%0d_ovf", g, done_n), sbus.overflow, e[GW+1]);
            check($sformatf("sw%0d_op%0d_latency", g, done_n), cyc - acc, GN);
          end
        end
        sbus.out_ready = 1'($urandom_range(0, 1));
        if (sbus.out_valid && sbus.out_ready) begin
          done_n++;
          seen = 1'b0;
          idle = 0;
        end
        if (idle > 400) begin
          fail_now($sformatf("sw%0d_result", g));
          abort = 1'b1;
        end
      end
      sweep_done++;
    end
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised ripple adder. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using a full-adder ripple slice.
- Serves as the area-reduced successor to the single-bit full adder in the arithmetic library. Datapaths that can trade latency for adder area instantiate it.
- Valid/ready handshakes on input and output. It holds one operation at a time.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be ≥1 and an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle. Must satisfy 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present on a/b/cin.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result on sum/cout/overflow is valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1 (unsigned overflow).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Definitions: NUM_CHUNKS = WIDTH/CHUNK. States are IDLE, RUN, DONE.
- Reset (rst high at a clock edge):
  - state → IDLE, chunk index → 0, internal carry → 0.
  - Output registers reset: sum = 0, cout = 0, overflow = 0, out_valid = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst deasserts.
- in_ready = (state == IDLE) && !rst, combinational from state. out_valid = (state == DONE), registered state.
- IDLE, on in_valid && in_ready at edge T:
  - Register a, b, cin into operand registers.
  - Carry register ← cin; chunk index ← 0; state → RUN.
  - in_valid without in_ready is ignored. Holding the input stable is the producer's obligation.
- RUN, each cycle:
  - The slice adds a[idx*CHUNK +: CHUNK] + b[idx*CHUNK +: CHUNK] + carry.
  - The slice result is written to sum[idx*CHUNK +: CHUNK]; carry ← slice carry-out; idx ← idx + 1.
  - On the cycle where idx == NUM_CHUNKS-1:
    - cout ← slice carry-out.
    - overflow ← slice MSB carry-in XOR slice carry-out.
    - state → DONE.
- Latency: accepted at edge T, out_valid is first high in the cycle after edge T+NUM_CHUNKS. With CHUNK == WIDTH this is 1 cycle after acceptance.
- DONE:
  - sum, cout and overflow are held stable while out_valid is high and out_ready is low. Backpressure is unlimited.
  - On out_valid && out_ready at an edge: state → IDLE. in_ready rises in the next cycle.
  - No same-cycle accept-on-drain. Maximum throughput is one operation per NUM_CHUNKS+2 cycles.
- sum bits not yet written in RUN hold their previous values. These values are not observable because out_valid = 0.
- Reset mid-RUN or mid-DONE:
  - The operation is abandoned and no result is produced.
  - out_valid drops at that edge.
  - in_ready returns 1 in the cycle after rst deasserts.
- out_ready in IDLE or RUN has no effect.
- Width rules:
  - Slice is CHUNK bits plus carry.
  - Chunk index width is max(1, $clog2(NUM_CHUNKS)).
  - No arithmetic wider than CHUNK+1 bits anywhere.
- Parameter violations (WIDTH % CHUNK != 0, CHUNK > WIDTH, CHUNK == 0) are flagged at elaboration with $error.

Decomposition:
- Shared package adder_pkg holds:
  - state enum {IDLE, RUN, DONE} as a 2-bit typedef;
  - function num_chunks(WIDTH, CHUNK);
  - index-width helper.
- One sub-module: chunk_ripple_adder #(CHUNK).
  - Combinational chain of CHUNK full-adder cells from the existing library.
  - Outputs: sum[CHUNK-1:0], cout, and c_msb (carry into bit CHUNK-1), used for overflow.
- The top level contains FSM, operand/result registers, index counter and carry register only.

Test Plan:
1. WIDTH=16, CHUNK=4, a=0xFFFF, b=0x0001, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x0000, cout=1, overflow=0; in_ready high 1 cycle after drain.
2. a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, overflow=1. Then a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, overflow=0.
3. Backpressure: complete a=0x00FF + b=0x0F01, hold out_ready=0 for 10 cycles → sum=0x1000 stable, out_valid=1, in_ready=0 throughout. A new in_valid pulse during this window is not accepted.
4. Reset mid-RUN: accept an op, assert rst at 2nd RUN cycle for 1 cycle → out_valid never rises for that op, in_ready=0 during rst and 1 the cycle after, and sum/cout/overflow=0.
5. Parameter sweep {WIDTH,CHUNK} = {8,8}, {8,1}, {32,4}: latency = NUM_CHUNKS (1, 8, 8). 1000 random operands per config, including random in_valid/out_ready gaps, checked against a behavioural a+b+cin model for sum, cout and overflow.
